// File: rtl/hdmi_video_out.sv
// 640x480@60 raster generator with 2x pixel/line doubling of the PPU frame.
// Three-clock fetch pipeline: row RAM -> palette RAM -> registered RGB pins.
module hdmi_video_out #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [8:0]  rowram_rdaddr,
  input  logic [9:0]  rowram_rddata,
  output logic [8:0]  palram_rdaddr,
  input  logic [63:0] palram_rddata,
  output logic        rowram_swap,
  output logic        vblank_start,
  output logic        vblank_end,
  output logic [23:0] hdmi_rgb,
  output logic        hdmi_de,
  output logic        hdmi_hsync,
  output logic        hdmi_vsync
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  logic [9:0]  hcount, vcount, hcount_nxt, vcount_nxt;
  logic        active_h, active, hsync_raw, vsync_raw;
  logic        vld_p0, half_p1;
  logic        de_p0, de_p1, de_p2;
  logic        hs_p0, hs_p1, hs_p2;
  logic        vs_p0, vs_p1, vs_p2;
  logic [23:0] rgb_p2;
  logic        unused_pal_bits;

  function automatic logic [23:0] select_colour(input logic [63:0] word, input logic half);
    return half ? word[55:32] : word[23:0];
  endfunction

  // Lines 1,3,..,V_ACTIVE-3 advance the PPU a row; the last two blanking lines prime row 0.
  function automatic logic swap_line(input logic [9:0] v);
    return (v[0] && (v <= 10'(V_ACTIVE - 3))) || (v == 10'(V_TOTAL - 2)) || (v == 10'(V_TOTAL - 1));
  endfunction

  always_comb begin
    hcount_nxt = hcount + 10'd1;
    vcount_nxt = vcount;
    if (hcount == 10'(H_TOTAL - 1)) begin
      hcount_nxt = 10'd0;
      vcount_nxt = (vcount == 10'(V_TOTAL - 1)) ? 10'd0 : vcount + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount <= 10'd0;
      vcount <= 10'd0;
    end else begin
      hcount <= hcount_nxt;
      vcount <= vcount_nxt;
    end
  end

  // Stage 0: decode counters, issue row-RAM address.
  assign active_h      = hcount < 10'(H_ACTIVE);
  assign active        = active_h && (vcount < 10'(V_ACTIVE));
  assign hsync_raw     = !((hcount >= 10'(HS_START)) && (hcount < 10'(HS_END)));
  assign vsync_raw     = !((vcount >= 10'(VS_START)) && (vcount < 10'(VS_END)));
  assign rowram_rdaddr = active_h ? hcount[9:1] : 9'd0;

  // Stage 1: row data returns; its upper bits address the palette word.
  assign palram_rdaddr   = vld_p0 ? rowram_rddata[9:1] : 9'd0;
  assign unused_pal_bits = ^{palram_rddata[63:56], palram_rddata[31:24]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      half_p1 <= 1'b0;
      de_p0   <= 1'b0;
      de_p1   <= 1'b0;
      de_p2   <= 1'b0;
      hs_p0   <= 1'b1;
      hs_p1   <= 1'b1;
      hs_p2   <= 1'b1;
      vs_p0   <= 1'b1;
      vs_p1   <= 1'b1;
      vs_p2   <= 1'b1;
      rgb_p2  <= 24'd0;
    end else begin
      vld_p0  <= active_h;
      half_p1 <= rowram_rddata[0];
      de_p0   <= active;
      de_p1   <= de_p0;
      de_p2   <= de_p1;
      hs_p0   <= hsync_raw;
      hs_p1   <= hs_p0;
      hs_p2   <= hs_p1;
      vs_p0   <= vsync_raw;
      vs_p1   <= vs_p0;
      vs_p2   <= vs_p1;
      // Stage 2: pick the palette half and blank outside the active window.
      rgb_p2  <= de_p1 ? select_colour(palram_rddata, half_p1) : 24'd0;
    end
  end

  assign hdmi_rgb   = rgb_p2;
  assign hdmi_de    = de_p2;
  assign hdmi_hsync = hs_p2;
  assign hdmi_vsync = vs_p2;

  // Strobes decode the next counter value so each pulse coincides with its raster position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblank_start <= 1'b0;
      vblank_end   <= 1'b0;
      rowram_swap  <= 1'b0;
    end else begin
      vblank_start <= (hcount_nxt == 10'd0) && (vcount_nxt == 10'(V_ACTIVE));
      vblank_end   <= (hcount_nxt == 10'd0) && (vcount_nxt == 10'(V_TOTAL - 3));
      rowram_swap  <= (hcount_nxt == 10'(H_ACTIVE)) && swap_line(vcount_nxt);
    end
  end

endmodule
